// File: rtl/button_conditioner.sv
// Push-button front end: two-flop synchronizer, debounce FSM with edge pulses,
// and a step-enable divider that runs while the debounced level is high.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TICK_DIV        = 8,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button_raw,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       step_tick,
    output logic [3:0] hold_steps
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_DIV - 1);

    logic             s0_q, s1_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             tick_q, tick_d;
    logic [3:0]       hold_q, hold_d;
    logic             sync;
    logic             run;

    assign sync = s1_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sync) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (!sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_MAX) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!sync) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            RELEASE_WAIT: begin
                if (sync) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_MAX) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Divider runs only while the level was high and stays high, so the
    // rising edge starts a full period and the falling edge kills any tick.
    always_comb begin
        level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
        run     = level_q && level_d;
        tick_d  = run && (tcnt_q == TICK_MAX);
        if (!run || tick_d) begin
            tcnt_d = '0;
        end else begin
            tcnt_d = tcnt_q + CNT_W'(1);
        end
        if (press_d) begin
            hold_d = 4'd0;
        end else if (tick_d && (hold_q != 4'd15)) begin
            hold_d = hold_q + 4'd1;
        end else begin
            hold_d = hold_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_q      <= 1'b0;
            s1_q      <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            tcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            tick_q    <= 1'b0;
            hold_q    <= 4'd0;
        end else begin
            s0_q      <= button_raw;
            s1_q      <= s0_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tcnt_q    <= tcnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            tick_q    <= tick_d;
            hold_q    <= hold_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign step_tick     = tick_q;
    assign hold_steps    = hold_q;

endmodule
